au_result_fifo: RTL and testbench

Registered result-capture stage that sits directly downstream of the 4-bit arithmetic unit (mux-selected B operand plus ripple adder). Each cycle that an operation is offered, it captures the unit's result `{cout, d}` together with the operation code. It derives the C/Z/N/V status flags and buffers entries in a small FIFO with valid/ready handshakes on both sides, so results can be consumed at a different rate than they are produced. It also counts operations lost to back-pressure.

---
 rtl/au_result_fifo.sv | 119 +++++++++++
 tb/tb_au_result_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/au_result_fifo.sv
// Result-capture FIFO behind the 4-bit arithmetic unit. It stores {d, C/Z/N/V flags, {s,cin}}
// for each accepted offer and counts offers refused while the FIFO is full.
module au_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [1:0]               in_s,
  input  logic                     in_cin,
  input  logic [3:0]               in_d,
  input  logic                     in_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_d,
  output logic [3:0]               out_flags,
  output logic [2:0]               out_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic [10:0]   mem_q [DEPTH];
  logic [10:0]   mem_d [DEPTH];

  logic [3:0]  y_eff;
  logic [3:0]  flags;
  logic [10:0] entry;
  logic        push;
  logic        pop;

  // Rebuild the effective B operand so V can be derived without the unit's internals.
  always_comb begin
    y_eff = in_b;
    case (in_s)
      2'b00:   y_eff = in_b;
      2'b01:   y_eff = ~in_b;
      2'b10:   y_eff = 4'b0000;
      default: y_eff = 4'b1111;
    endcase
  end

  always_comb begin
    flags[3] = in_cout;
    flags[2] = (in_d == 4'b0000);
    flags[1] = in_d[3];
    flags[0] = (in_a[3] == y_eff[3]) && (in_d[3] != in_a[3]);
    entry    = {in_d, flags, in_s, in_cin};
  end

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (in_valid && !in_ready && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign {out_d, out_flags, out_op} = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_au_result_fifo.sv
// Directed-vector bench for au_result_fifo (DEPTH=4) with hand-computed expectations.
module tb_au_result_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] in_s;
  logic       in_cin;
  logic [3:0] in_d;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_d;
  logic [3:0] out_flags;
  logic [2:0] out_op;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  au_result_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_s      (in_s),
    .in_cin    (in_cin),
    .in_d      (in_d),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_flags (out_flags),
    .out_op    (out_op),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #40 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                        input logic cin, input logic [3:0] d, input logic cout);
    in_a    = a;
    in_b    = b;
    in_s    = s;
    in_cin  = cin;
    in_d    = d;
    in_cout = cout;
  endtask

  task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                          input logic cin, input logic [3:0] d, input logic cout);
    set_in(a, b, s, cin, d, cout);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_in(4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_out_d", 32'(out_d), 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_op", 32'(out_op), 32'd0);

    // add with overflow
    push_one(4'b0101, 4'b0011, 2'b00, 1'b0, 4'b1000, 1'b0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_d", 32'(out_d), 32'b1000);
    chk("add_flags", 32'(out_flags), 32'b0011);
    chk("add_op", 32'(out_op), 32'b000);
    chk("add_count", 32'(count), 32'd1);
    pop_one();
    chk("add_pop_count", 32'(count), 32'd0);
    chk("add_pop_valid", 32'(out_valid), 32'd0);

    // subtract to zero
    push_one(4'b0011, 4'b0011, 2'b01, 1'b1, 4'b0000, 1'b1);
    chk("sub_d", 32'(out_d), 32'b0000);
    chk("sub_flags", 32'(out_flags), 32'b1100);
    chk("sub_op", 32'(out_op), 32'b011);
    pop_one();

    // constant B selects, popped in push order
    push_one(4'b1111, 4'b0000, 2'b10, 1'b1, 4'b0000, 1'b1);
    push_one(4'b0000, 4'b0000, 2'b11, 1'b0, 4'b1111, 1'b0);
    chk("const_count", 32'(count), 32'd2);
    chk("const0_d", 32'(out_d), 32'b0000);
    chk("const0_flags", 32'(out_flags), 32'b1100);
    chk("const0_op", 32'(out_op), 32'b101);
    pop_one();
    chk("const1_d", 32'(out_d), 32'b1111);
    chk("const1_flags", 32'(out_flags), 32'b0010);
    chk("const1_op", 32'(out_op), 32'b110);
    pop_one();
    chk("const_empty", 32'(out_valid), 32'd0);

    // full and drop: six offers, four accepted
    for (int i = 1; i <= 6; i++) begin
      push_one(4'd0, 4'd0, 2'b00, 1'b0, 4'(i), 1'b0);
      if (i == 4) begin
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_drop0", 32'(drop_cnt), 32'd0);
      end
    end
    chk("drop_cnt2", 32'(drop_cnt), 32'd2);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_head_stable", 32'(out_d), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_d", 32'(out_d), 32'(i));
      chk("drain_flags", 32'(out_flags), 32'd0);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);

    // simultaneous push/pop with pointer wrap
    push_one(4'd0, 4'd0, 2'b00, 1'b0, 4'd1, 1'b0);
    push_one(4'd0, 4'd0, 2'b00, 1'b0, 4'd2, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(4'd0, 4'd0, 2'b00, 1'b0, 4'(i + 3), 1'b0);
      chk("pp_head", 32'(out_d), 32'(i + 1));
      tick();
      chk("pp_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    chk("pp_tail0", 32'(out_d), 32'd11);
    tick();
    chk("pp_tail1", 32'(out_d), 32'd12);
    tick();
    out_ready = 1'b0;
    chk("pp_empty", 32'(out_valid), 32'd0);
    chk("pp_drop_kept", 32'(drop_cnt), 32'd2);

    // reset mid-stream with 3 entries and drop_cnt=5
    for (int i = 0; i < 4; i++) push_one(4'd0, 4'd0, 2'b00, 1'b0, 4'(i + 5), 1'b0);
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    pop_one();
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_drop", 32'(drop_cnt), 32'd5);
    chk("mid_head", 32'(out_d), 32'd6);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    tick();
    chk("mid_rst_hold", 32'(count), 32'd0);

    // drop counter saturation
    for (int i = 0; i < 4; i++) push_one(4'd0, 4'd0, 2'b00, 1'b0, 4'd9, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    chk("sat_254", 32'(drop_cnt), 32'd254);
    for (int i = 0; i < 6; i++) tick();
    in_valid = 1'b0;
    chk("sat_255", 32'(drop_cnt), 32'd255);
    chk("sat_count", 32'(count), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
